mem_port_master: RTL and testbench
==================================

// Module: mem_port_master
// PURPOSE
//  Initiator side of the data-memory port: accepts load/store requests from the MEM pipeline stage
//  over a valid/ready handshake and drives the word-wide Memory block (ren, wen, addr, din, dout).
//  Supports lb/lbu/lh/lhu/lw/sb/sh/sw. Sub-word stores use read-modify-write.
//  The Memory writes on the clock negedge and never sees ren and wen high together.
// PARAMETERS
//  MEM_IDX_W   10  width of the Memory word index; word index >= 2**MEM_IDX_W is out of range
//  BIG_ENDIAN  1   1: byte offset 0 = bits [31:24] (MIPS); 0: byte offset 0 = bits [7:0]
// PORTS
//  clock        in   1   single system clock; all state changes on posedge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   block can accept a request (high only in IDLE)
//  req_we       in   1   1 = store, 0 = load
//  req_size     in   2   00 byte, 01 half, 10 word, 11 reserved (error)
//  req_signed   in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data; the sub-word is taken from the LSBs
//  resp_valid   out  1   one-cycle pulse: request complete
//  resp_rdata   out  32  load result (extended); 0 for stores and errors
//  resp_err     out  1   qualified by resp_valid: misaligned, reserved size or out of range
//  mem_ren      out  1   Memory read enable
//  mem_wen      out  1   Memory write enable
//  mem_addr     out  32  Memory word index = {2'b00, req_addr[31:2]}
//  mem_din      out  32  Memory write data
//  mem_dout     in   32  Memory read data (combinational while mem_ren=1 and mem_wen=0)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; all outputs 0 except req_ready=1. Any in-flight access is abandoned.
//    Memory gates its own write with reset, so no partial write occurs.
//  - All outputs are registered and decoded from state. ren and wen are never high in the same cycle,
//    and never high in adjacent cycles of different requests without passing through IDLE.
//  - Accept: req_valid & req_ready at posedge T latches we, size, signed, addr and wdata. Inputs are
//    ignored outside IDLE.
//  - Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, size=11, or addr[31:2] >= 2**MEM_IDX_W.
//    On error: go to RESP; cycle T+1 has resp_valid=1, resp_err=1, resp_rdata=0. No ren or wen.
//  - States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
//    - Load:     IDLE->RD. ren=1 in cycle T+1; the extracted lane of mem_dout is captured at the end of T+1.
//                RD->RESP; resp_valid in T+2.
//    - sw:       IDLE->WR. wen=1, din=wdata in T+1. WR->RESP; resp_valid in T+2.
//    - sb/sh:    IDLE->RMW_RD (ren=1, capture word) in T+1, then RMW_WR (wen=1, din=merged word) in T+2.
//                RMW_WR->RESP; resp_valid in T+3.
//    - RESP->IDLE unconditionally. req_ready returns to 1 the cycle after resp_valid.
//  - Lane select: byte k = addr[1:0], half h = addr[1]. With BIG_ENDIAN=1, byte k = bits [31-8k -: 8]
//    and half h = bits [31-16h -: 16].
//  - Merge: only the addressed lane is replaced, with wdata[7:0] or wdata[15:0]. Other lanes keep the read value.
//  - mem_addr is held stable from the first access cycle through the last one.
// TESTING
//  1. sw addr=0x10 wdata=0xDEADBEEF, then lw 0x10 -> mem_addr=0x4, wen 1 cycle, resp at T+2; lw resp_rdata=0xDEADBEEF, err=0.
//  2. After 1: lb 0x11 -> 0xFFFFFFAD; lbu 0x13 -> 0x000000EF; lh 0x12 -> 0xFFFFBEEF; lhu 0x10 -> 0x0000DEAD.
//  3. sb 0x12 wdata=0x12345655 -> ren T+1, wen T+2 (never overlapping), din=0xDEAD55EF; lw 0x10 then returns 0xDEAD55EF.
//  4. lw 0x06, sh 0x11, size=11 and lw 0x1000 -> each gives resp_valid at T+1, resp_err=1, rdata=0, no ren/wen.
//  5. sh 0x10 with reset pulled low during RMW_RD -> all outputs 0 at once, word at 0x10 unchanged, req_ready=1 after release.
//  6. req_valid held high with 3 queued loads -> one accept per IDLE visit; ready low from accept through resp; no request lost or duplicated.

Source files
------------

// File: rtl/mem_port_master.sv
// mem_port_master: valid/ready load/store initiator for the word-wide data Memory, with read-modify-write for sub-word stores
module mem_port_master #(
    parameter int MEM_IDX_W  = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
    state_t state;
    logic [1:0] size, offs;
    logic sgn, bad;
    logic [31:0] wdata, load_val, merged;
    logic [4:0] bsh, hsh;
    logic [7:0] lane_b;
    logic [15:0] lane_h;
    always_comb begin
        bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00) || (req_addr[31:2] >> MEM_IDX_W) != 30'd0;
        bsh = BIG_ENDIAN ? 5'd24 - {offs, 3'b000} : {offs, 3'b000};
        hsh = (BIG_ENDIAN != offs[1]) ? 5'd16 : 5'd0;
        lane_b = 8'(mem_dout >> bsh);
        lane_h = 16'(mem_dout >> hsh);
        load_val = size == 2'b00 ? {{24{sgn & lane_b[7]}}, lane_b} :
                   size == 2'b01 ? {{16{sgn & lane_h[15]}}, lane_h} : mem_dout;
        merged = size == 2'b00 ? (mem_dout & ~(32'hFF << bsh)) | ({24'd0, wdata[7:0]} << bsh) :
                                 (mem_dout & ~(32'hFFFF << hsh)) | ({16'd0, wdata[15:0]} << hsh);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            size       <= '0;
            offs       <= '0;
            sgn        <= 1'b0;
            wdata      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    size      <= req_size;
                    offs      <= req_addr[1:0];
                    sgn       <= req_signed;
                    wdata     <= req_wdata;
                    if (bad) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        mem_addr <= {2'b00, req_addr[31:2]};
                        if (!req_we) begin
                            state   <= RD;
                            mem_ren <= 1'b1;
                        end else if (req_size == 2'b10) begin
                            state   <= WR;
                            mem_wen <= 1'b1;
                            mem_din <= req_wdata;
                        end else begin
                            state   <= RMW_RD;
                            mem_ren <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state      <= RESP;
                    mem_ren    <= 1'b0;
                    mem_addr   <= '0;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_val;
                end
                RMW_RD: begin
                    state   <= RMW_WR;
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b1;
                    mem_din <= merged;
                end
                WR, RMW_WR: begin
                    state      <= RESP;
                    mem_wen    <= 1'b0;
                    mem_din    <= '0;
                    mem_addr   <= '0;
                    resp_valid <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: vector table, corner sequences and random traffic against a byte-addressed big-endian memory model
module tb_mem_port_master;
    logic clock = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic req_ready, resp_valid, resp_err, mem_ren, mem_wen;
    logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
    logic [31:0] mem [1024];
    logic [7:0] rb [4096];
    int checks = 0, errors = 0;

    mem_port_master dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (reset && mem_wen) mem[mem_addr[9:0]] <= mem_din;
    assign mem_dout = (mem_ren && !mem_wen) ? mem[mem_addr[9:0]] : 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a >= 32'd4096;
    endfunction

    function automatic logic [31:0] m_word(input int w);
        return {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]};
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [15:0] h;
        h = {rb[a], rb[a+1]};
        if (sz == 2'd0) return sg ? 32'($signed(rb[a])) : 32'(rb[a]);
        if (sz == 2'd1) return sg ? 32'($signed(h)) : 32'(h);
        return m_word(int'(a / 4));
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) rb[a] = wd[7:0];
        else if (sz == 2'd1) begin rb[a] = wd[15:8]; rb[a+1] = wd[7:0]; end
        else begin rb[a] = wd[31:24]; rb[a+1] = wd[23:16]; rb[a+2] = wd[15:8]; rb[a+3] = wd[7:0]; end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, wd,
                          input int exp_lat, input logic [31:0] exp_din,
                          output logic [31:0] rd, output logic er);
        int n, lat, nren, nwen, rcyc, wcyc;
        n = 0; lat = 0; nren = 0; nwen = 0; rcyc = 0; wcyc = 0; rd = '0; er = 1'b0;
        while (!req_ready && n < 20) begin @(posedge clock); #1; n++; end
        chk("ready_before_req", req_ready, 1);
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            if (mem_ren && mem_wen) chk("ren_wen_overlap", 1, 0);
            if (mem_ren || mem_wen) chk("mem_addr", mem_addr, {2'b00, a[31:2]});
            if (mem_ren) begin nren++; rcyc = c; end
            if (mem_wen) begin nwen++; wcyc = c; chk("mem_din", mem_din, exp_din); end
            if (req_ready) chk("ready_busy", req_ready, 0);
            if (resp_valid) begin lat = c; rd = resp_rdata; er = resp_err; end
            else begin @(posedge clock); #1; end
        end
        chk("latency", lat, exp_lat);
        chk("ren_cycles", nren, (exp_lat == 1 || (we && sz == 2'd2)) ? 0 : 1);
        chk("wen_cycles", nwen, (exp_lat != 1 && we) ? 1 : 0);
        if (nren == 1 && nwen == 1) chk("rmw_order", wcyc, rcyc + 1);
        @(posedge clock); #1;
        chk("ready_after_resp", req_ready, 1);
        chk("resp_pulse", resp_valid, 0);
    endtask

    typedef struct {
        logic we; logic [1:0] sz; logic sg; logic [31:0] a, wd, rd, din; logic err; int lat;
    } vec_t;
    vec_t tv[20];

    initial begin
        logic [31:0] rd, exp_rd, din, ba [3];
        logic er, e, we, sg, will;
        logic [1:0] sz, bs [3];
        logic [31:0] a, wd;
        int lat, acc, nresp;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4096; i++) rb[i] = '0;
        tv[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        tv[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 2};
        tv[2]  = '{1'b0, 2'd0, 1'b1, 32'h11,  32'h0,        32'hFFFFFFAD, 32'h0,        1'b0, 2};
        tv[3]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h000000EF, 32'h0,        1'b0, 2};
        tv[4]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'hFFFFBEEF, 32'h0,        1'b0, 2};
        tv[5]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h0,        32'h0000DEAD, 32'h0,        1'b0, 2};
        tv[6]  = '{1'b1, 2'd0, 1'b0, 32'h12,  32'h12345655, 32'h0,        32'hDEAD55EF, 1'b0, 3};
        tv[7]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEAD55EF, 32'h0,        1'b0, 2};
        tv[8]  = '{1'b0, 2'd2, 1'b0, 32'h06,  32'h0,        32'h0,        32'h0,        1'b1, 1};
        tv[9]  = '{1'b1, 2'd1, 1'b0, 32'h11,  32'h5555,     32'h0,        32'h0,        1'b1, 1};
        tv[10] = '{1'b0, 2'd3, 1'b0, 32'h20,  32'h0,        32'h0,        32'h0,        1'b1, 1};
        tv[11] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,       32'h0,        32'h0,        1'b1, 1};
        tv[12] = '{1'b1, 2'd2, 1'b0, 32'hFFC, 32'h80000001, 32'h0,        32'h80000001, 1'b0, 2};
        tv[13] = '{1'b0, 2'd1, 1'b1, 32'hFFC, 32'h0,        32'hFFFF8000, 32'h0,        1'b0, 2};
        tv[14] = '{1'b0, 2'd1, 1'b0, 32'hFFE, 32'h0,        32'h00000001, 32'h0,        1'b0, 2};
        tv[15] = '{1'b1, 2'd1, 1'b0, 32'hFFE, 32'hABCD1234, 32'h0,        32'h80001234, 1'b0, 3};
        tv[16] = '{1'b0, 2'd0, 1'b1, 32'hFFF, 32'h0,        32'h00000034, 32'h0,        1'b0, 2};
        tv[17] = '{1'b0, 2'd0, 1'b1, 32'hFFE, 32'h0,        32'h00000012, 32'h0,        1'b0, 2};
        tv[18] = '{1'b0, 2'd0, 1'b0, 32'hFFC, 32'h0,        32'h00000080, 32'h0,        1'b0, 2};
        tv[19] = '{1'b0, 2'd0, 1'b1, 32'hFFC, 32'h0,        32'hFFFFFF80, 32'h0,        1'b0, 2};

        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_din", mem_din, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        for (int i = 0; i < 20; i++) begin
            do_req(tv[i].we, tv[i].sz, tv[i].sg, tv[i].a, tv[i].wd, tv[i].lat, tv[i].din, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
            chk($sformatf("vec%0d_err", i), er, tv[i].err);
            if (tv[i].we && !m_err(tv[i].sz, tv[i].a)) m_store(tv[i].a, tv[i].sz, tv[i].wd);
        end

        // reset dropped while the read half of a halfword RMW is in flight
        req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0000AAAA; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("rmw_rd_ren", mem_ren, 1);
        reset = 1'b0;
        #1;
        chk("async_ready", req_ready, 1);
        chk("async_ren", mem_ren, 0);
        chk("async_wen", mem_wen, 0);
        chk("async_resp_valid", resp_valid, 0);
        chk("async_addr", mem_addr, 0);
        chk("async_din", mem_din, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_word", mem[4], m_word(4));
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 2, 32'h0, rd, er);
        chk("post_rst_lw", rd, m_word(4));

        // three loads queued behind a continuously asserted req_valid
        ba = '{32'h10, 32'h12, 32'h13};
        bs = '{2'd2, 2'd1, 2'd0};
        acc = 0; nresp = 0;
        req_we = 1'b0; req_signed = 1'b0; req_addr = ba[0]; req_size = bs[0]; req_valid = 1'b1;
        for (int c = 0; c < 40 && nresp < 3; c++) begin
            will = req_ready && req_valid;
            @(posedge clock); #1;
            if (mem_ren && mem_wen) chk("b2b_overlap", 1, 0);
            if (will) begin
                acc++;
                if (acc < 3) begin req_addr = ba[acc]; req_size = bs[acc]; end
                else req_valid = 1'b0;
            end
            if (resp_valid) begin
                chk("b2b_ready_low", req_ready, 0);
                chk($sformatf("b2b_rdata%0d", nresp), resp_rdata, m_load(ba[nresp], bs[nresp], 1'b0));
                nresp++;
            end
        end
        chk("b2b_accepts", acc, 3);
        chk("b2b_responses", nresp, 3);
        @(posedge clock); #1;

        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            sg = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 11) == 0) ? 32'h1000 + $urandom_range(0, 255) : 32'($urandom_range(0, 63));
            wd = $urandom;
            e = m_err(sz, a);
            lat = e ? 1 : (we && sz != 2'd2) ? 3 : 2;
            exp_rd = (e || we) ? 32'h0 : m_load(a, sz, sg);
            din = 32'h0;
            if (!e && we) begin m_store(a, sz, wd); din = m_word(int'(a / 4)); end
            do_req(we, sz, sg, a, wd, lat, din, rd, er);
            chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
            chk($sformatf("rand%0d_err", i), er, e);
        end

        for (int w = 0; w < 1024; w++) chk($sformatf("mem_word%0d", w), mem[w], m_word(w));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
